mem_port_arbiter: RTL

Owns the single byte-wide RAM port and shares it between instruction fetch (IF) and the load/store stage (MEM). Multi-byte requests are serialised into byte accesses, and the returned bytes are reassembled into 32-bit words. The block drives the per-requester stall lines that feed the pipeline stall controller. MEM has priority because it carries the older instruction.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_byte_buf.sv | 36 +++
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the byte-wide RAM port arbiter.
// State/owner encodings, request length codes and small byte-lane helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Illegal length codes fall back to a full word.
  function automatic logic [2:0] req_len(input logic [2:0] len);
    case (len)
      LEN_B:   return LEN_B;
      LEN_H:   return LEN_H;
      default: return LEN_W;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_buf.sv
// 32-bit reassembly register: one byte lane written per strobe, cleared at grant.
// word_next exposes the post-edge value so completion can latch the final byte.
module mem_byte_buf
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [31:0] word_next
);

  logic [31:0] word_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next[gi*8 +: 8] = clr ? 8'h00 :
                                    (wr && lane == 2'(gi)) ? din : word_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg <= '0;
    end else begin
      word_reg <= word_next;
    end
  end

  assign word = word_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered byte-wide RAM port between instruction fetch and load/store,
// serialising multi-byte requests and reassembling read bytes into 32-bit words.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [31:0]           if_data,
  output logic                  if_stall,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [2:0]            mem_len,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  mem_stall,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  state_t                state_reg, state_next;
  owner_t                owner_reg, owner_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [2:0]            len_reg, len_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [2:0]            cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] mem_a_reg, mem_a_next;
  logic                  mem_wr_reg, mem_wr_next;
  logic [7:0]            mem_dout_reg, mem_dout_next;
  logic                  if_done_reg, if_done_next;
  logic                  mem_done_reg, mem_done_next;
  logic [31:0]           if_data_reg, if_data_next;
  logic [31:0]           mem_rdata_reg, mem_rdata_next;

  logic [2:0]  cnt_p1;
  logic        grant_any;
  logic        if_abort;
  logic        buf_clr;
  logic        buf_wr;
  logic [1:0]  buf_lane;
  logic [31:0] buf_word;
  logic [31:0] buf_word_next;

  assign cnt_p1    = cnt_reg + 3'd1;
  assign grant_any = (state_reg == ST_IDLE) && (mem_req || (if_req && !if_flush));
  assign if_abort  = (state_reg == ST_RD) && (owner_reg == OWN_IF) && if_flush;

  // RAM latency is two edges, so byte i lands when the counter reads i+1.
  assign buf_clr  = grant_any;
  assign buf_wr   = (state_reg == ST_RD) && (cnt_reg != 3'd0) && !if_abort;
  assign buf_lane = cnt_reg[1:0] - 2'd1;

  mem_byte_buf u_byte_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .wr        (buf_wr),
    .lane      (buf_lane),
    .din       (mem_din),
    .word      (buf_word),
    .word_next (buf_word_next)
  );

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    addr_next      = addr_reg;
    len_next       = len_reg;
    wdata_next     = wdata_reg;
    cnt_next       = cnt_reg;
    mem_a_next     = mem_a_reg;
    mem_wr_next    = mem_wr_reg;
    mem_dout_next  = mem_dout_reg;
    if_done_next   = 1'b0;
    mem_done_next  = 1'b0;
    if_data_next   = if_data_reg;
    mem_rdata_next = mem_rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (mem_req) begin
          owner_next = OWN_MEM;
          addr_next  = mem_addr;
          len_next   = req_len(mem_len);
          wdata_next = mem_wdata;
          cnt_next   = 3'd0;
          mem_a_next = mem_addr;
          if (mem_we) begin
            state_next    = ST_WR;
            mem_wr_next   = 1'b1;
            mem_dout_next = mem_wdata[7:0];
          end else begin
            state_next = ST_RD;
          end
        end else if (if_req && !if_flush) begin
          owner_next = OWN_IF;
          addr_next  = if_addr;
          len_next   = LEN_W;
          cnt_next   = 3'd0;
          mem_a_next = if_addr;
          state_next = ST_RD;
        end
      end

      ST_RD: begin
        if (if_abort) begin
          state_next = ST_IDLE;
          mem_a_next = '0;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_p1;
          if (cnt_p1 < len_reg) begin
            mem_a_next = addr_reg + ADDR_WIDTH'(cnt_p1);
          end
          if (cnt_reg == len_reg) begin
            state_next = ST_DONE;
            if (owner_reg == OWN_MEM) begin
              mem_done_next  = 1'b1;
              mem_rdata_next = buf_word_next;
            end else begin
              if_done_next = 1'b1;
              if_data_next = buf_word_next;
            end
          end
        end
      end

      ST_WR: begin
        if (cnt_p1 < len_reg) begin
          cnt_next      = cnt_p1;
          mem_a_next    = addr_reg + ADDR_WIDTH'(cnt_p1);
          mem_dout_next = byte_of(wdata_reg, cnt_p1[1:0]);
        end else begin
          mem_wr_next   = 1'b0;
          mem_done_next = 1'b1;
          state_next    = ST_DONE;
        end
      end

      default: begin
        // One quiet cycle so requesters can drop req after seeing done.
        mem_a_next  = '0;
        mem_wr_next = 1'b0;
        state_next  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= OWN_IF;
      addr_reg      <= '0;
      len_reg       <= '0;
      wdata_reg     <= '0;
      cnt_reg       <= '0;
      mem_a_reg     <= '0;
      mem_wr_reg    <= 1'b0;
      mem_dout_reg  <= '0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      if_data_reg   <= '0;
      mem_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      addr_reg      <= addr_next;
      len_reg       <= len_next;
      wdata_reg     <= wdata_next;
      cnt_reg       <= cnt_next;
      mem_a_reg     <= mem_a_next;
      mem_wr_reg    <= mem_wr_next;
      mem_dout_reg  <= mem_dout_next;
      if_done_reg   <= if_done_next;
      mem_done_reg  <= mem_done_next;
      if_data_reg   <= if_data_next;
      mem_rdata_reg <= mem_rdata_next;
    end
  end

  assign if_done   = if_done_reg;
  assign if_data   = if_data_reg;
  assign if_stall  = if_req & ~if_done_reg;
  assign mem_done  = mem_done_reg;
  assign mem_rdata = mem_rdata_reg;
  assign mem_stall = mem_req & ~mem_done_reg;
  assign mem_a     = mem_a_reg;
  assign mem_wr    = mem_wr_reg;
  assign mem_dout  = mem_dout_reg;

  logic unused_ok;
  assign unused_ok = ^buf_word;

endmodule
